mmu_fork_buf: RTL and testbench

Parametrised synchronous fork (splitter) for the MMU request path. It accepts one token ({mask, data}) per handshake and broadcasts it to every output channel selected by the mask. Each channel completes independently. A token retires only when all of its selected channels have handshaken. A DEPTH-entry input buffer decouples the producer from the slowest consumer. The block sits between the MMU request source and the per-way/TLB-port consumers, and generalises the fixed 6-way splitter with selectable destinations, buffering and drop accounting.

---
 rtl/mmu_fork_buf.sv | 124 ++++++++++++
 tb/tb_mmu_fork_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mmu_fork_buf.sv
`default_nettype none
// ============================================================================
// mmu_fork_buf : buffered masked fork, broadcasts each token to its mask set
// Rev 1.0
// ============================================================================
module mmu_fork_buf #(
  parameter int NUM_PORTS = 6,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [DATA_W-1:0]    i_data,
  input  logic [NUM_PORTS-1:0] i_mask,
  output logic [NUM_PORTS-1:0] o_valid,
  input  logic [NUM_PORTS-1:0] i_ready,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] c_ONE_CNT  = (PTR_W+1)'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BCAST = 1'b1
  } state_t;

  logic [NUM_PORTS-1:0] mask_mem_q [DEPTH];
  logic [DATA_W-1:0]    data_mem_q [DEPTH];

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [NUM_PORTS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     drop_q, drop_d;

  logic                 w_accept, w_store, w_drop, w_retire;
  logic [NUM_PORTS-1:0] w_hs;

  assign o_ready    = (count_q != c_FULL_CNT);
  assign o_busy     = (count_q != '0);
  assign o_valid    = (state_q == S_BCAST) ? pending_q : '0;
  assign o_data     = (state_q == S_BCAST) ? data_mem_q[rd_ptr_q] : '0;
  assign o_drop_cnt = drop_q;

  assign w_accept = i_valid & o_ready;
  assign w_store  = w_accept & (|i_mask);
  assign w_drop   = w_accept & ~(|i_mask);
  assign w_hs     = o_valid & i_ready;
  assign w_retire = (state_q == S_BCAST) && ((pending_q & ~w_hs) == '0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q & ~w_hs;
    wr_ptr_d  = wr_ptr_q + PTR_W'(w_store);
    rd_ptr_d  = rd_ptr_q + PTR_W'(w_retire);
    count_d   = count_q + (PTR_W+1)'(w_store) - (PTR_W+1)'(w_retire);
    drop_d    = drop_q;
    if (w_drop && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        // Buffer is empty here, so the token lands at rd_ptr and can launch at once.
        pending_d = '0;
        if (w_store) begin
          pending_d = i_mask;
          state_d   = S_BCAST;
        end
      end
      S_BCAST: begin
        if (w_retire) begin
          if (count_q > c_ONE_CNT) begin
            pending_d = mask_mem_q[rd_ptr_d];
          end else if (w_store) begin
            pending_d = i_mask;
          end else begin
            pending_d = '0;
            state_d   = S_IDLE;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  // Storage is not reset: entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (w_store) begin
      mask_mem_q[wr_ptr_q] <= i_mask;
      data_mem_q[wr_ptr_q] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmu_fork_buf.sv
`default_nettype none
// ============================================================================
// tb_mmu_fork_buf : directed self-checking bench for mmu_fork_buf
// Rev 1.0
// ============================================================================
module tb_mmu_fork_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data = '0;
  logic [5:0]  i_mask = '0;
  logic [5:0]  o_valid;
  logic [5:0]  i_ready = '0;
  logic [31:0] o_data;
  logic        o_busy;
  logic [7:0]  o_drop_cnt;

  logic        i_valid2 = 1'b0;
  logic        o_ready2;
  logic [31:0] o_data2;
  logic [5:0]  o_valid2;
  logic        o_busy2;
  logic [1:0]  o_drop_cnt2;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mmu_fork_buf #(.NUM_PORTS(6), .DATA_W(32), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_mask(i_mask), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_busy(o_busy), .o_drop_cnt(o_drop_cnt)
  );

  mmu_fork_buf #(.NUM_PORTS(6), .DATA_W(32), .DEPTH(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .i_valid(i_valid2), .o_ready(o_ready2),
    .i_data(32'h0), .i_mask(6'h00), .o_valid(o_valid2), .i_ready(6'h3F),
    .o_data(o_data2), .o_busy(o_busy2), .o_drop_cnt(o_drop_cnt2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL reset_valid got=%h exp=00", o_valid); end
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    vec++; if (o_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    vec++; if (o_drop_cnt !== 8'd0) begin errs++; $display("FAIL reset_drop got=%0d exp=0", o_drop_cnt); end
    vec++; if (o_data !== 32'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", o_data); end
  endtask

  task automatic test_all_ready();
    i_ready = 6'h3F;
    i_valid = 1'b1; i_mask = 6'h3F; i_data = 32'hA5A5_0001;
    cyc();
    i_valid = 1'b0;
    vec++; if (o_valid !== 6'h3F) begin errs++; $display("FAIL allrdy_valid got=%h exp=3f", o_valid); end
    vec++; if (o_data !== 32'hA5A5_0001) begin errs++; $display("FAIL allrdy_data got=%h exp=a5a50001", o_data); end
    vec++; if (o_busy !== 1'b1) begin errs++; $display("FAIL allrdy_busy got=%b exp=1", o_busy); end
    cyc();
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL allrdy_valid_end got=%h exp=00", o_valid); end
    vec++; if (o_busy !== 1'b0) begin errs++; $display("FAIL allrdy_busy_end got=%b exp=0", o_busy); end
  endtask

  task automatic test_stagger();
    logic [5:0] exp_v;
    i_ready = 6'h00;
    i_valid = 1'b1; i_mask = 6'h3F; i_data = 32'h1111_2222;
    cyc();
    i_valid = 1'b0;
    vec++; if (o_valid !== 6'h3F) begin errs++; $display("FAIL stagger_start got=%h exp=3f", o_valid); end
    for (int k = 0; k < 6; k++) begin
      // ready accumulates: a re-asserted valid on a done channel would handshake again
      i_ready = 6'((2 << k) - 1);
      exp_v   = 6'(6'h3F << (k + 1));
      cyc();
      vec++; if (o_valid !== exp_v) begin errs++; $display("FAIL stagger_valid k=%0d got=%h exp=%h", k, o_valid, exp_v); end
      vec++; if (o_busy !== (k < 5)) begin errs++; $display("FAIL stagger_busy k=%0d got=%b exp=%b", k, o_busy, (k < 5)); end
      if (k < 5) begin
        vec++; if (o_data !== 32'h1111_2222) begin errs++; $display("FAIL stagger_data k=%0d got=%h exp=11112222", k, o_data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    i_ready = 6'h3F;
    i_valid = 1'b1; i_mask = 6'h05; i_data = 32'h0000_00D1;
    cyc();
    vec++; if (o_valid !== 6'h05) begin errs++; $display("FAIL b2b_first got=%h exp=05", o_valid); end
    vec++; if (o_data !== 32'h0000_00D1) begin errs++; $display("FAIL b2b_first_data got=%h exp=d1", o_data); end
    i_mask = 6'h12; i_data = 32'h0000_00D2;
    cyc();
    i_valid = 1'b0;
    vec++; if (o_valid !== 6'h12) begin errs++; $display("FAIL b2b_second got=%h exp=12", o_valid); end
    vec++; if (o_data !== 32'h0000_00D2) begin errs++; $display("FAIL b2b_second_data got=%h exp=d2", o_data); end
    cyc();
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL b2b_end got=%h exp=00", o_valid); end
    vec++; if (o_busy !== 1'b0) begin errs++; $display("FAIL b2b_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_backpressure();
    i_ready = 6'h00;
    i_valid = 1'b1; i_mask = 6'h3F; i_data = 32'h0000_00B0;
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL bp_ready0 got=%b exp=1", o_ready); end
    cyc();
    i_data = 32'h0000_00B1;
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL bp_ready1 got=%b exp=1", o_ready); end
    cyc();
    i_data = 32'h0000_00B2;
    vec++; if (o_ready !== 1'b0) begin errs++; $display("FAIL bp_full got=%b exp=0", o_ready); end
    cyc();
    vec++; if (o_ready !== 1'b0) begin errs++; $display("FAIL bp_hold got=%b exp=0", o_ready); end
    vec++; if (o_data !== 32'h0000_00B0) begin errs++; $display("FAIL bp_head0 got=%h exp=b0", o_data); end
    i_ready = 6'h3F;
    cyc();
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL bp_freed got=%b exp=1", o_ready); end
    vec++; if (o_valid !== 6'h3F) begin errs++; $display("FAIL bp_valid1 got=%h exp=3f", o_valid); end
    vec++; if (o_data !== 32'h0000_00B1) begin errs++; $display("FAIL bp_head1 got=%h exp=b1", o_data); end
    cyc();
    i_valid = 1'b0;
    vec++; if (o_valid !== 6'h3F) begin errs++; $display("FAIL bp_valid2 got=%h exp=3f", o_valid); end
    vec++; if (o_data !== 32'h0000_00B2) begin errs++; $display("FAIL bp_head2 got=%h exp=b2", o_data); end
    cyc();
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL bp_end got=%h exp=00", o_valid); end
    vec++; if (o_busy !== 1'b0) begin errs++; $display("FAIL bp_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_drop();
    i_ready = 6'h3F;
    i_valid = 1'b1; i_mask = 6'h00; i_data = 32'hDEAD_0000;
    cyc();
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL drop_novalid0 got=%h exp=00", o_valid); end
    i_mask = 6'h01; i_data = 32'h0000_00C1;
    cyc();
    vec++; if (o_valid !== 6'h01) begin errs++; $display("FAIL drop_tok1 got=%h exp=01", o_valid); end
    vec++; if (o_data !== 32'h0000_00C1) begin errs++; $display("FAIL drop_tok1_data got=%h exp=c1", o_data); end
    i_mask = 6'h00; i_data = 32'hDEAD_0001;
    cyc();
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL drop_novalid1 got=%h exp=00", o_valid); end
    i_mask = 6'h02; i_data = 32'h0000_00C2;
    cyc();
    vec++; if (o_valid !== 6'h02) begin errs++; $display("FAIL drop_tok2 got=%h exp=02", o_valid); end
    i_mask = 6'h00; i_data = 32'hDEAD_0002;
    cyc();
    i_valid = 1'b0;
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL drop_novalid2 got=%h exp=00", o_valid); end
    vec++; if (o_drop_cnt !== 8'd3) begin errs++; $display("FAIL drop_cnt got=%0d exp=3", o_drop_cnt); end
    i_valid2 = 1'b1;
    repeat (2) cyc();
    vec++; if (o_drop_cnt2 !== 2'd2) begin errs++; $display("FAIL drop_sat_mid got=%0d exp=2", o_drop_cnt2); end
    repeat (3) cyc();
    i_valid2 = 1'b0;
    vec++; if (o_drop_cnt2 !== 2'd3) begin errs++; $display("FAIL drop_sat got=%0d exp=3", o_drop_cnt2); end
    vec++; if (o_valid2 !== 6'h00) begin errs++; $display("FAIL drop_sat_valid got=%h exp=00", o_valid2); end
  endtask

  task automatic test_reset_mid();
    i_ready = 6'h00;
    i_valid = 1'b1; i_mask = 6'h28; i_data = 32'h0000_00E0;
    cyc();
    i_valid = 1'b0;
    vec++; if (o_valid !== 6'h28) begin errs++; $display("FAIL rmid_pending got=%h exp=28", o_valid); end
    #2;
    rst = 1'b1;
    #1;
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL rmid_valid got=%h exp=00", o_valid); end
    vec++; if (o_ready !== 1'b1) begin errs++; $display("FAIL rmid_ready got=%b exp=1", o_ready); end
    vec++; if (o_busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got=%b exp=0", o_busy); end
    vec++; if (o_drop_cnt !== 8'd0) begin errs++; $display("FAIL rmid_drop got=%0d exp=0", o_drop_cnt); end
    cyc();
    rst = 1'b0;
    i_ready = 6'h3F;
    i_valid = 1'b1; i_mask = 6'h3F; i_data = 32'h0000_00F0;
    cyc();
    i_valid = 1'b0;
    vec++; if (o_valid !== 6'h3F) begin errs++; $display("FAIL rmid_after got=%h exp=3f", o_valid); end
    vec++; if (o_data !== 32'h0000_00F0) begin errs++; $display("FAIL rmid_after_data got=%h exp=f0", o_data); end
    cyc();
    vec++; if (o_valid !== 6'h00) begin errs++; $display("FAIL rmid_after_end got=%h exp=00", o_valid); end
  endtask

  initial begin
    #100000;
    errs++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    test_reset();
    test_all_ready();
    test_stagger();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
